// File: rtl/alu_dispatch_if.sv
// alu_dispatch_if: bundles the command, ALU and response ports of alu_dispatch.
// The slave modport is the dispatcher's view; the master modport is the view of
// the surrounding logic (command producer, ALU and response consumer).
interface alu_dispatch_if #(
    parameter int OPCODE_WIDTH = 2,
    parameter int DATA_WIDTH   = 9,
    parameter int PTR_WIDTH    = 2
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [OPCODE_WIDTH-1:0] cmd_opcode;
    logic [DATA_WIDTH-2:0]   cmd_opa;
    logic [DATA_WIDTH-2:0]   cmd_opb;
    logic                    alu_wr;
    logic [OPCODE_WIDTH-1:0] alu_opcode;
    logic [DATA_WIDTH-1:0]   alu_opa;
    logic [DATA_WIDTH-1:0]   alu_opb;
    logic                    alu_done;
    logic                    alu_status;
    logic [DATA_WIDTH-1:0]   alu_res;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_res;
    logic                    rsp_status;
    logic [OPCODE_WIDTH-1:0] rsp_opcode;
    logic                    rsp_timeout;
    logic                    rsp_err;
    logic [PTR_WIDTH:0]      fifo_count;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_opa, cmd_opb,
        input  alu_done, alu_status, alu_res,
        input  rsp_ready,
        output cmd_ready, alu_wr, alu_opcode, alu_opa, alu_opb,
        output rsp_valid, rsp_res, rsp_status, rsp_opcode, rsp_timeout, rsp_err,
        output fifo_count
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_opa, cmd_opb,
        output alu_done, alu_status, alu_res,
        output rsp_ready,
        input  cmd_ready, alu_wr, alu_opcode, alu_opa, alu_opb,
        input  rsp_valid, rsp_res, rsp_status, rsp_opcode, rsp_timeout, rsp_err,
        input  fifo_count
    );
endinterface

// File: rtl/alu_dispatch.sv
// alu_dispatch: command FIFO plus sequencer in front of the Moore-FSM alu.
// Requests are queued, issued one at a time over the wr/done handshake, and the
// ALU answer is returned over a valid/ready response port. A watchdog bounds
// every ALU transaction so a stuck ALU produces a timeout response instead of a hang.
// Optional feature: define ALU_DISPATCH_CHECK_EN to add a result reference model
// that drives rsp_err; without it rsp_err is tied low.
module alu_dispatch #(
    parameter int OPCODE_WIDTH = 2,
    parameter int DATA_WIDTH   = 9,
    parameter int DEPTH        = 4,
    parameter int PTR_WIDTH    = 2,
    parameter int TIMEOUT      = 64
) (
    input logic           clk,
    input logic           rstn,
    alu_dispatch_if.slave bus
);
    localparam int OPND_WIDTH  = DATA_WIDTH - 1;
    localparam int ENTRY_WIDTH = OPCODE_WIDTH + 2 * OPND_WIDTH;
    localparam int WD_WIDTH    = $clog2(TIMEOUT);
    localparam logic [PTR_WIDTH:0]  FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]  ZERO_COUNT = {(PTR_WIDTH + 1){1'b0}};
    localparam logic [WD_WIDTH-1:0] WD_LAST    = WD_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ENTRY_WIDTH-1:0]  fifo_mem_r [DEPTH];
    logic [PTR_WIDTH-1:0]    wr_ptr_r;
    logic [PTR_WIDTH-1:0]    rd_ptr_r;
    logic [PTR_WIDTH:0]      count_r;
    logic [WD_WIDTH-1:0]     wd_r;
    logic                    push_s;
    logic                    pop_s;
    logic                    capture_s;
    logic                    expire_s;
    logic                    release_s;
    logic                    mismatch_s;
    logic [ENTRY_WIDTH-1:0]  head_s;
    logic [OPCODE_WIDTH-1:0] head_opcode_s;
    logic [OPND_WIDTH-1:0]   head_opa_s;
    logic [OPND_WIDTH-1:0]   head_opb_s;
    logic                    alu_wr_r;
    logic [OPCODE_WIDTH-1:0] alu_opcode_r;
    logic [DATA_WIDTH-1:0]   alu_opa_r;
    logic [DATA_WIDTH-1:0]   alu_opb_r;
    logic                    rsp_valid_r;
    logic [DATA_WIDTH-1:0]   rsp_res_r;
    logic                    rsp_status_r;
    logic [OPCODE_WIDTH-1:0] rsp_opcode_r;
    logic                    rsp_timeout_r;
    logic                    rsp_err_r;

    // cmd_ready looks only at registered occupancy, so a same-cycle pop never raises it
    assign bus.cmd_ready  = (count_r != FULL_COUNT);
    assign bus.fifo_count = count_r;
    assign push_s         = bus.cmd_valid && (count_r != FULL_COUNT);

    assign head_s        = fifo_mem_r[rd_ptr_r];
    assign head_opcode_s = head_s[ENTRY_WIDTH-1 -: OPCODE_WIDTH];
    assign head_opa_s    = head_s[2*OPND_WIDTH-1 -: OPND_WIDTH];
    assign head_opb_s    = head_s[OPND_WIDTH-1:0];

`ifdef ALU_DISPATCH_CHECK_EN
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_SHR = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_SHL = OPCODE_WIDTH'(3);

    function automatic logic [DATA_WIDTH-1:0] expected_result(
        input logic [OPCODE_WIDTH-1:0] op,
        input logic [DATA_WIDTH-1:0]   a,
        input logic [DATA_WIDTH-1:0]   b
    );
        logic [DATA_WIDTH-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SHR:  r = a >> b;
            OP_SHL:  r = a << b;
            default: r = {DATA_WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // Operand lines are held for the whole transaction, so they are valid at capture
    assign mismatch_s = (bus.alu_res != expected_result(alu_opcode_r, alu_opa_r, alu_opb_r));
`else
    assign mismatch_s = 1'b0;
`endif

    // Sequencer state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sequencer next state and one-cycle action strobes; done beats the watchdog in WAIT
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        capture_s   = 1'b0;
        expire_s    = 1'b0;
        release_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != ZERO_COUNT) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (wd_r == WD_LAST) begin
                    expire_s    = 1'b1;
                    state_nxt_s = ST_RESP;
                end else if (!bus.alu_done) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (bus.alu_done) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_RESP;
                end else if (wd_r == WD_LAST) begin
                    expire_s    = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    release_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FIFO storage; stale entries are harmless because only the pointers define contents
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {bus.cmd_opcode, bus.cmd_opa, bus.cmd_opb};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {PTR_WIDTH{1'b0}};
            rd_ptr_r <= {PTR_WIDTH{1'b0}};
            count_r  <= ZERO_COUNT;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_WIDTH'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_WIDTH'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_WIDTH + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_WIDTH + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Watchdog: cleared at issue, counts each cycle the ALU transaction is open
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_r <= {WD_WIDTH{1'b0}};
        end else if (pop_s) begin
            wd_r <= {WD_WIDTH{1'b0}};
        end else if ((state_r == ST_ISSUE || state_r == ST_WAIT) && !capture_s && !expire_s) begin
            wd_r <= wd_r + WD_WIDTH'(1);
        end else begin
            wd_r <= wd_r;
        end
    end

    // ALU request lines and response registers; responses stay frozen while in RESP
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alu_wr_r      <= 1'b0;
            alu_opcode_r  <= {OPCODE_WIDTH{1'b0}};
            alu_opa_r     <= {DATA_WIDTH{1'b0}};
            alu_opb_r     <= {DATA_WIDTH{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_res_r     <= {DATA_WIDTH{1'b0}};
            rsp_status_r  <= 1'b0;
            rsp_opcode_r  <= {OPCODE_WIDTH{1'b0}};
            rsp_timeout_r <= 1'b0;
            rsp_err_r     <= 1'b0;
        end else if (pop_s) begin
            alu_wr_r     <= 1'b1;
            alu_opcode_r <= head_opcode_s;
            alu_opa_r    <= {1'b0, head_opa_s};
            alu_opb_r    <= {1'b0, head_opb_s};
        end else if (capture_s) begin
            alu_wr_r      <= 1'b0;
            rsp_valid_r   <= 1'b1;
            rsp_res_r     <= bus.alu_res;
            rsp_status_r  <= bus.alu_status;
            rsp_opcode_r  <= alu_opcode_r;
            rsp_timeout_r <= 1'b0;
            rsp_err_r     <= mismatch_s;
        end else if (expire_s) begin
            alu_wr_r      <= 1'b0;
            rsp_valid_r   <= 1'b1;
            rsp_res_r     <= {DATA_WIDTH{1'b0}};
            rsp_status_r  <= 1'b0;
            rsp_opcode_r  <= alu_opcode_r;
            rsp_timeout_r <= 1'b1;
            rsp_err_r     <= 1'b0;
        end else if (release_s) begin
            rsp_valid_r <= 1'b0;
        end else begin
            alu_wr_r    <= alu_wr_r;
            rsp_valid_r <= rsp_valid_r;
        end
    end

    assign bus.alu_wr      = alu_wr_r;
    assign bus.alu_opcode  = alu_opcode_r;
    assign bus.alu_opa     = alu_opa_r;
    assign bus.alu_opb     = alu_opb_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_res     = rsp_res_r;
    assign bus.rsp_status  = rsp_status_r;
    assign bus.rsp_opcode  = rsp_opcode_r;
    assign bus.rsp_timeout = rsp_timeout_r;
    assign bus.rsp_err     = rsp_err_r;
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: randomized scoreboard bench for alu_dispatch. A behavioural
// ALU stand-in answers the wr/done handshake with a per-command latency or fault,
// the expected response of each accepted command is queued at acceptance, and a
// monitor pops and compares whenever a response appears.
module tb_alu_dispatch;
    localparam int OPCODE_WIDTH = 2;
    localparam int DATA_WIDTH   = 9;
    localparam int DEPTH        = 4;
    localparam int PTR_WIDTH    = 2;
    localparam int TIMEOUT      = 64;
    localparam int STUCK_LOW    = -1;
    localparam int STUCK_HIGH   = -2;
`ifdef ALU_DISPATCH_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    alu_dispatch_if #(.OPCODE_WIDTH(OPCODE_WIDTH), .DATA_WIDTH(DATA_WIDTH), .PTR_WIDTH(PTR_WIDTH)) bus ();

    alu_dispatch #(
        .OPCODE_WIDTH(OPCODE_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH),
        .PTR_WIDTH(PTR_WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         lat;
        bit         corrupt;
    } cmd_t;

    typedef struct {
        logic [8:0] res;
        logic       status;
        logic [1:0] op;
        logic       timeout;
        logic       err;
    } rsp_t;

    cmd_t alu_q[$];
    rsp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Specification arithmetic on zero-extended operands, modulo 2^9
    function automatic int unsigned ref_calc(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned ua = a;
        int unsigned ub = b;
        int unsigned r;
        case (op)
            2'd0:    r = ua + ub;
            2'd1:    r = ua + 512 - ub;
            2'd2:    r = (ub >= 32) ? 0 : (ua >> ub);
            default: r = (ub >= 32) ? 0 : (ua << ub);
        endcase
        return r % 512;
    endfunction

    // Expected response: the ALU answers lat+2 cycles after issue; beyond TIMEOUT it is a timeout
    function automatic rsp_t expect_for(input cmd_t c);
        rsp_t e;
        int unsigned r;
        e.op = c.op;
        if (c.lat < 0 || c.lat + 2 > TIMEOUT) begin
            e.res = 9'd0; e.status = 1'b0; e.timeout = 1'b1; e.err = 1'b0;
        end else begin
            r = ref_calc(c.op, c.a, c.b);
            if (c.corrupt) r = (r + 1) % 512;
            e.res = 9'(r); e.status = (r == 0); e.timeout = 1'b0;
            e.err = CHECK_EN && c.corrupt;
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int lat, input bit corrupt);
        cmd_t c;
        int   guard = 0;
        c.op = op; c.a = a; c.b = b; c.lat = lat; c.corrupt = corrupt;
        bus.cmd_valid = 1'b1; bus.cmd_opcode = op; bus.cmd_opa = a; bus.cmd_opb = b;
        while (!bus.cmd_ready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (bus.cmd_ready) begin
            alu_q.push_back(c);
            exp_q.push_back(expect_for(c));
            @(negedge clk);
        end else begin
            chk("push_accept_timeout", 32'd0, 32'd1);
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Response consumer: held low, held high, or random backpressure
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.rsp_ready = 1'b0;
                1:       bus.rsp_ready = 1'b1;
                default: bus.rsp_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Behavioural ALU: drops done on wr, raises it with the result after the command's latency
    initial begin
        int   mstate = 0;
        int   cnt    = 0;
        bit   raised = 1'b0;
        cmd_t cur;
        int unsigned r;
        bus.alu_done = 1'b1; bus.alu_status = 1'b0; bus.alu_res = 9'd0;
        forever begin
            @(negedge clk);
            if (raised && rstn) chk("rsp_latency", 32'(bus.rsp_valid), 32'd1);
            raised = 1'b0;
            if (!rstn || !bus.alu_wr) begin
                mstate = 0;
                bus.alu_done = 1'b1;
            end else if (mstate == 0) begin
                if (alu_q.size() == 0) begin
                    chk("alu_unexpected_wr", 32'd1, 32'd0);
                    mstate = 2;
                end else begin
                    cur = alu_q.pop_front();
                    chk("alu_operand_lines", {12'd0, bus.alu_opcode, bus.alu_opa, bus.alu_opb},
                        {12'd0, cur.op, 1'b0, cur.a, 1'b0, cur.b});
                    if (cur.lat == STUCK_HIGH) begin
                        mstate = 2;
                    end else begin
                        bus.alu_done = 1'b0;
                        cnt = cur.lat;
                        mstate = (cur.lat == STUCK_LOW) ? 2 : 1;
                    end
                end
            end else if (mstate == 1) begin
                if (cnt == 0) begin
                    r = ref_calc(cur.op, cur.a, cur.b);
                    if (cur.corrupt) r = (r + 1) % 512;
                    bus.alu_res = 9'(r); bus.alu_status = (r == 0); bus.alu_done = 1'b1;
                    raised = 1'b1;
                    mstate = 2;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: pops the scoreboard once per response and watches it stay stable
    initial begin
        bit          seen     = 1'b0;
        int          run      = 0;
        int          last_run = 0;
        rsp_t        e;
        logic [13:0] held     = 14'd0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                seen = 1'b0; run = 0;
            end else begin
                if (bus.alu_wr) begin
                    run++;
                end else begin
                    if (run != 0) last_run = run;
                    run = 0;
                end
                if (bus.rsp_valid && !seen) begin
                    seen = 1'b1;
                    held = {bus.rsp_res, bus.rsp_status, bus.rsp_opcode, bus.rsp_timeout, bus.rsp_err};
                    if (exp_q.size() == 0) begin
                        chk("unexpected_response", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_res", 32'(bus.rsp_res), 32'(e.res));
                        chk("rsp_status", 32'(bus.rsp_status), 32'(e.status));
                        chk("rsp_opcode", 32'(bus.rsp_opcode), 32'(e.op));
                        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.timeout));
                        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                        chk("alu_wr_low_in_resp", 32'(bus.alu_wr), 32'd0);
                        if (e.timeout) chk("watchdog_cycles", 32'(last_run), 32'(TIMEOUT));
                    end
                end else if (bus.rsp_valid) begin
                    chk("rsp_stable", 32'({bus.rsp_res, bus.rsp_status, bus.rsp_opcode,
                                           bus.rsp_timeout, bus.rsp_err}), 32'(held));
                end
                if (!bus.rsp_valid) seen = 1'b0;
            end
        end
    end

    // Stimulus sequence
    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_opcode = 2'd0; bus.cmd_opa = 8'd0; bus.cmd_opb = 8'd0;
        #3;
        chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("reset_fifo_count", 32'(bus.fifo_count), 32'd0);
        chk("reset_alu_wr", 32'(bus.alu_wr), 32'd0);
        chk("reset_alu_lines", 32'({bus.alu_opcode, bus.alu_opa, bus.alu_opb}), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_fields", 32'({bus.rsp_res, bus.rsp_status, bus.rsp_opcode,
                                     bus.rsp_timeout, bus.rsp_err}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Single add with issue latency
        rdy_mode = 1;
        push(2'd0, 8'd200, 8'd100, 2, 1'b0);
        chk("issue_latency_before", 32'(bus.alu_wr), 32'd0);
        @(negedge clk);
        chk("issue_latency_after", 32'(bus.alu_wr), 32'd1);
        drain();

        // Backpressure: one in flight, FIFO full, then release in order
        rdy_mode = 0;
        @(negedge clk);
        push(2'd1, 8'd5, 8'd7, 1, 1'b0);
        push(2'd3, 8'd255, 8'd3, 0, 1'b0);
        push(2'd0, 8'd10, 8'd20, 3, 1'b0);
        push(2'd2, 8'd200, 8'd1, 1, 1'b0);
        push(2'd1, 8'd100, 8'd3, 2, 1'b0);
        repeat (20) @(negedge clk);
        chk("full_fifo_count", 32'(bus.fifo_count), 32'd4);
        chk("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        fork
            begin
                repeat (5) @(negedge clk);
                rdy_mode = 1;
            end
            push(2'd0, 8'd255, 8'd255, 0, 1'b0);
        join
        drain();

        // Watchdog: stuck high, stuck low, done exactly at expiry, one cycle late
        push(2'd3, 8'd1, 8'd1, STUCK_HIGH, 1'b0);
        drain();
        push(2'd2, 8'd9, 8'd1, STUCK_LOW, 1'b0);
        drain();
        push(2'd0, 8'd7, 8'd8, TIMEOUT - 2, 1'b0);
        drain();
        push(2'd1, 8'd7, 8'd8, TIMEOUT - 1, 1'b0);
        drain();

        // Wrong ALU answer for shr 128>>2
        push(2'd2, 8'd128, 8'd2, 0, 1'b1);
        drain();

        // Reset while waiting on the ALU with two commands queued
        push(2'd0, 8'd1, 8'd2, 30, 1'b0);
        push(2'd1, 8'd3, 8'd4, 0, 1'b0);
        push(2'd3, 8'd5, 8'd6, 0, 1'b0);
        repeat (5) @(negedge clk);
        chk("midwait_fifo_count", 32'(bus.fifo_count), 32'd2);
        chk("midwait_alu_wr", 32'(bus.alu_wr), 32'd1);
        rstn = 1'b0;
        #1;
        chk("midreset_alu_wr", 32'(bus.alu_wr), 32'd0);
        chk("midreset_fifo_count", 32'(bus.fifo_count), 32'd0);
        chk("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        alu_q.delete();
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        push(2'd0, 8'd17, 8'd25, 1, 1'b0);
        drain();

        // Randomized traffic with random latency and backpressure
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            logic [7:0] b;
            op = 2'($urandom_range(0, 3));
            b  = (op[1] && $urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            push(op, 8'($urandom), b, $urandom_range(0, 4), 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound on simulation time
    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Command buffer and sequencer placed directly upstream of the Moore-FSM `alu`. It accepts operation requests through a valid/ready port and queues them in a small FIFO. It issues one request at a time to the ALU using the `wr`/`done` handshake, then returns the ALU's `res` and `status` through a valid/ready response port. A watchdog bounds every ALU transaction, so a stuck ALU cannot hang the pipeline.

## Interface
- `OPCODE_WIDTH`, 2, opcode width; matches `alu`.
- `DATA_WIDTH`, 9, ALU result width; operands are `DATA_WIDTH-1` bits.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `PTR_WIDTH`, 2, log2(`DEPTH`).
- `TIMEOUT`, 64, maximum cycles per ALU transaction; ≥4.

Ports:
- `clk` in 1: the only clock; rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: request present.
- `cmd_ready` out 1: FIFO not full.
- `cmd_opcode` in `OPCODE_WIDTH`: 00 add, 01 sub, 10 shift right, 11 shift left.
- `cmd_opa` in `DATA_WIDTH-1`: operand A.
- `cmd_opb` in `DATA_WIDTH-1`: operand B.
- `alu_wr` out 1: ALU write request.
- `alu_opcode` out `OPCODE_WIDTH`: to ALU.
- `alu_opa` out `DATA_WIDTH`: to ALU, zero-extended.
- `alu_opb` out `DATA_WIDTH`: to ALU, zero-extended.
- `alu_done` in 1: from ALU.
- `alu_status` in 1: from ALU.
- `alu_res` in `DATA_WIDTH`: from ALU.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts.
- `rsp_res` out `DATA_WIDTH`: captured result.
- `rsp_status` out 1: captured ALU status.
- `rsp_opcode` out `OPCODE_WIDTH`: opcode of the answered request.
- `rsp_timeout` out 1: the transaction hit the watchdog.
- `rsp_err` out 1: result mismatch flag (see Configuration).
- `fifo_count` out `PTR_WIDTH+1`: current occupancy.

## Operation
- **FIFO.**
  - A push occurs when `cmd_valid && cmd_ready`.
  - `cmd_ready = (fifo_count != DEPTH)` and depends only on registered occupancy.
  - A same-cycle pop does not raise `cmd_ready` in that cycle.
  - Read and write pointers wrap modulo `DEPTH`.
  - A simultaneous push and pop leaves the count unchanged.
- **FSM states:**
  - IDLE:
    - If the FIFO is non-empty, pop the head and register its fields into `alu_opcode`/`alu_opa`/`alu_opb`.
    - Set `alu_wr=1`, clear the watchdog, and go to ISSUE.
  - ISSUE: hold `alu_wr=1`. When `alu_done==0` is sampled, go to WAIT.
  - WAIT:
    - Hold `alu_wr=1`.
    - When `alu_done==1` is sampled, capture `alu_res`/`alu_status` into `rsp_*`, set `alu_wr=0`, `rsp_valid=1`, and go to RESP.
  - RESP:
    - `rsp_valid=1`, with all `rsp_*` signals stable.
    - On `rsp_ready`, set `rsp_valid=0` and go to IDLE.
- **Watchdog.**
  - The counter increments every cycle in ISSUE and WAIT.
  - When it reaches `TIMEOUT-1`, go to RESP with `rsp_timeout=1`, `rsp_res=0`, `rsp_status=0`, and `alu_wr=0`.
  - If `alu_done` rises in the same cycle the watchdog expires, the done takes priority: the result is captured and `rsp_timeout=0`.
- **Ordering.** Responses are returned in command order, with exactly one response per accepted command.
- **ALU operand lines.** `alu_opcode`/`alu_opa`/`alu_opb` hold their values from the IDLE pop until the next pop.

## Timing
- **Reset values (asynchronous):**
  - `cmd_ready=1`, `fifo_count=0`, state IDLE, pointers 0.
  - `alu_wr=0`, `alu_opcode=0`, `alu_opa=0`, `alu_opb=0`.
  - `rsp_valid=0`, `rsp_res=0`, `rsp_status=0`, `rsp_opcode=0`, `rsp_timeout=0`, `rsp_err=0`.
- **Reset mid-transaction.** The FIFO contents are discarded and `alu_wr` drops immediately; no response is produced.
- **Latency.**
  - Command accepted into an empty FIFO at edge N: `alu_wr=1` after edge N+1.
  - `alu_done` rise sampled at edge M: `rsp_valid=1` after edge M.
- **Throughput.** With `rsp_ready` held high, the minimum turnaround is 1 cycle in RESP plus 1 cycle in IDLE between ALU transactions.

## Configuration
- **`ALU_DISPATCH_CHECK_EN` defined.** An internal reference model computes the expected value at capture time, using the operands zero-extended to `DATA_WIDTH` and truncated modulo 2^`DATA_WIDTH`:
  - add: `opa+opb`
  - sub: `opa-opb`
  - shift right: `opa>>opb`
  - shift left: `opa<<opb`
- `rsp_err=1` when `rsp_res` differs from the expected value. It is 0 on a timeout response.
- **Not defined.** The model is absent and `rsp_err` is tied to 0.

## Test plan
- **Reset.** Hold `rstn=0` for 10 ns -> all outputs take their reset values and `cmd_ready=1`.
- **Single add.** Push add, `opa=200`, `opb=100`, with `rsp_ready=1` -> `alu_wr` pulse ends at done; response `rsp_res=300`, `rsp_opcode=00`, `rsp_timeout=0`, `rsp_err=0`.
- **Backpressure and full.**
  - With `rsp_ready=0`, push 6 commands -> 1 is in flight and 4 are queued, `fifo_count=4`, `cmd_ready=0`.
  - Then release `rsp_ready` -> responses arrive in order (sub 5-7 -> `rsp_res=510`; shl 255<<3 -> `rsp_res=504`).
- **Timeout.** Hold `alu_done=1` stuck, or never return it to 1 -> response after `TIMEOUT` cycles with `rsp_timeout=1`, `rsp_res=0`, and `alu_wr=0`.
- **Reset mid-WAIT.**
  - Assert `rstn=0` while in WAIT with 2 commands queued -> `alu_wr=0` immediately, `fifo_count=0`, no response.
  - A subsequent command completes normally.
- **Check build.** With `ALU_DISPATCH_CHECK_EN` defined, force the ALU model to return `res+1` for shr 128>>2 -> `rsp_res=33`, `rsp_err=1`.
